load_store_unit: RTL and testbench

//  Initiator side of the data-memory interface: accepts load/store requests from the core pipeline

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_align.sv | 43 ++++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states, response codes
// and the request legality helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // dmem is only ever accessed as a full word
  localparam logic [2:0] DMEM_MASK_WORD = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_e;

  typedef enum logic [1:0] {
    OK       = 2'b00,
    MISALIGN = 2'b01,
    RANGE    = 2'b10,
    ILLEGAL  = 2'b11
  } lsu_err_e;

  // Unsigned variants exist only for loads.
  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane handling for the load/store unit: extracts and extends the selected byte/half of a
// loaded word, and merges sub-word store data into the old word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // NOTE: every output of a combinational block gets a default first; a path that leaves one unassigned infers a latch.
  always_comb begin
    sel_byte   = old_word[{lane, 3'b000} +: 8];
    sel_half   = lane[1] ? old_word[31:16] : old_word[15:0];
    load_data  = old_word;
    store_word = old_word;

    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_data = {24'h0, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_data = {16'h0, sel_half};
      default: load_data = old_word;
    endcase

    // Only the addressed lane changes; the neighbouring bytes come from the word just read.
    case (funct3[1:0])
      2'b00: store_word[{lane, 3'b000} +: 8] = store_data[7:0];
      2'b01: begin
        if (lane[1]) store_word[31:16] = store_data[15:0];
        else         store_word[15:0]  = store_data[15:0];
      end
      default: store_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: valid/ready request -> whole-word dmem accesses, sub-word loads by extraction,
// sub-word stores by read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DMEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wr_data,
  output logic        dmem_mem_wr,
  output logic        dmem_mem_rd,
  output logic [2:0]  dmem_mask,
  input  logic [31:0] dmem_rdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(DMEM_DEPTH * 4);

  lsu_state_e  state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic [31:0] dmem_addr_q;
  logic [31:0] wr_data_q;
  logic [31:0] rdata_q;
  lsu_err_e    err_q;

  logic        accept;
  lsu_err_e    req_err;
  logic [31:0] req_addr_eff;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign accept = req_valid && req_ready;

  // Request classification, evaluated on the raw address; the effective address drops the
  // low bits that a half/word access cannot use.
  always_comb begin
    req_addr_eff = req_addr;
    case (req_funct3[1:0])
      2'b01:   req_addr_eff[0]   = 1'b0;
      2'b10:   req_addr_eff[1:0] = 2'b00;
      default: ;
    endcase

    if (!funct3_legal(req_we, req_funct3)) req_err = ILLEGAL;
    else if (req_addr >= ADDR_LIMIT)       req_err = RANGE;
`ifdef LSU_MISALIGN_TRAP_EN
    else if (req_addr != req_addr_eff)     req_err = MISALIGN;
`endif
    else                                   req_err = OK;
  end

  // NOTE: sequential state uses non-blocking (<=) so all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    dmem_mem_rd = 1'b0;
    dmem_mem_wr = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (req_err != OK)                            state_d = RESP;
          else if (!req_we || req_funct3[1:0] != 2'b10) state_d = READ;
          else                                          state_d = WRITE;
        end
      end
      READ: begin
        dmem_mem_rd = 1'b1;
        state_d     = we_q ? WRITE : RESP;
      end
      WRITE: begin
        dmem_mem_wr = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      lane_q      <= 2'b00;
      wdata_q     <= '0;
      dmem_addr_q <= '0;
      wr_data_q   <= '0;
      rdata_q     <= '0;
      err_q       <= OK;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            lane_q   <= req_addr_eff[1:0];
            wdata_q  <= req_wdata;
            err_q    <= req_err;
            rdata_q  <= '0;
            // Faulting requests leave the dmem-facing registers untouched.
            if (req_err == OK) begin
              dmem_addr_q <= {req_addr_eff[31:2], 2'b00};
              wr_data_q   <= req_wdata;
            end
          end
        end
        READ: begin
          if (we_q) wr_data_q <= store_word;
          else      rdata_q   <= load_data;
        end
        RESP: begin
          if (rsp_ready) begin
            rdata_q <= '0;
            err_q   <= OK;
          end
        end
        default: ;
      endcase
    end
  end

  lsu_align u_align (
    .funct3     (funct3_q),
    .lane       (lane_q),
    .old_word   (dmem_rdata),
    .store_data (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wr_data = wr_data_q;
  assign dmem_mask    = DMEM_MASK_WORD;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model, word-wide dmem model,
// directed scenarios followed by randomized traffic with random response back-pressure.
module tb_load_store_unit;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
    int          rd_n;
    int          wr_n;
    logic [31:0] waddr;
    logic [31:0] wword;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] dmem_addr, dmem_wr_data, dmem_rdata;
  logic        dmem_mem_wr, dmem_mem_rd;
  logic [2:0]  dmem_mask;

  load_store_unit #(.DMEM_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .dmem_addr    (dmem_addr),
    .dmem_wr_data (dmem_wr_data),
    .dmem_mem_wr  (dmem_mem_wr),
    .dmem_mem_rd  (dmem_mem_rd),
    .dmem_mask    (dmem_mask),
    .dmem_rdata   (dmem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0]  ref_mem [DEPTH*4];
  logic [31:0] dmem [DEPTH];
  logic [2:0]  legal_ld [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  exp_t sb_q[$];
  int   acc_q[$];
  int   cycle    = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rdy_mode = 0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] word_of(input int byte_addr);
    return {ref_mem[byte_addr+3], ref_mem[byte_addr+2], ref_mem[byte_addr+1], ref_mem[byte_addr]};
  endfunction

  assign dmem_rdata = dmem[dmem_addr[AW+1:2]];

  // dmem model: copy of the reference image at start, then writes commit on the falling edge.
  initial begin
    #1;
    for (int i = 0; i < DEPTH; i++) dmem[i] = word_of(4*i);
    forever begin
      @(negedge clk);
      if (dmem_mem_wr) dmem[dmem_addr[AW+1:2]] = dmem_wr_data;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: byte-addressed memory, size = 1 << funct3[1:0], extension from funct3[2].
  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    int          nb;
    logic        legal;
    logic [31:0] a, val, lowmask;
    nb      = 1 << f3[1:0];
    legal   = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e.rdata = '0; e.err = 2'b00; e.lat = 1; e.rd_n = 0; e.wr_n = 0; e.waddr = '0; e.wword = '0;
    a = addr;
    if (!legal)                        e.err = 2'b11;
    else if (addr >= 32'(DEPTH * 4))   e.err = 2'b10;
    else if (addr % nb != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
      e.err = 2'b01;
`else
      a = addr - addr % nb;
`endif
    end
    if (e.err == 2'b00) begin
      e.waddr = a & ~32'h3;
      if (we) begin
        for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
        e.wword = word_of(int'(e.waddr));
        e.wr_n  = 1;
        e.rd_n  = (nb < 4) ? 1 : 0;
        e.lat   = (nb < 4) ? 3 : 2;
      end else begin
        val = '0;
        for (int i = 0; i < nb; i++) val[8*i +: 8] = ref_mem[int'(a) + i];
        lowmask = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8*nb)) - 32'h1;
        if (!f3[2] && nb < 4 && val[8*nb-1]) val = val | ~lowmask;
        e.rdata = val;
        e.rd_n  = 1;
        e.lat   = 2;
      end
    end
    return e;
  endfunction

  // Monitor: checks every dmem access and every response against the scoreboard head.
  initial begin
    int rd_n = 0;
    int wr_n = 0;
    bit seen = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_n = 0; wr_n = 0; seen = 0;
      end else begin
        if (dmem_mem_rd || dmem_mem_wr) begin
          if (sb_q.size() == 0) begin
            check("spurious_access", 32'(dmem_mem_rd | dmem_mem_wr), 32'd0);
          end else begin
            check("dmem_addr", dmem_addr, sb_q[0].waddr);
            check("dmem_mask", 32'(dmem_mask), 32'd2);
            if (dmem_mem_wr) check("dmem_wr_data", dmem_wr_data, sb_q[0].wword);
          end
          if (dmem_mem_rd) rd_n++;
          if (dmem_mem_wr) wr_n++;
        end
        if (rsp_valid) begin
          check("req_ready_busy", 32'(req_ready), 32'd0);
          if (sb_q.size() == 0) begin
            check("unexpected_rsp", 32'(rsp_valid), 32'd0);
          end else begin
            if (!seen && acc_q.size() != 0) check("latency", 32'(cycle - acc_q[0] + 1), 32'(sb_q[0].lat));
            seen = 1;
            check("rsp_rdata", rsp_rdata, sb_q[0].rdata);
            check("rsp_err", 32'(rsp_err), 32'(sb_q[0].err));
            if (rsp_ready) begin
              check("mem_rd_cycles", 32'(rd_n), 32'(sb_q[0].rd_n));
              check("mem_wr_cycles", 32'(wr_n), 32'(sb_q[0].wr_n));
              void'(sb_q.pop_front());
              if (acc_q.size() != 0) void'(acc_q.pop_front());
              rd_n = 0; wr_n = 0; seen = 0;
            end
          end
        end
        if (req_valid && req_ready) acc_q.push_back(cycle + 1);
      end
    end
  end

  // Response sink: 0 always ready, 1 random back-pressure, 2 stalled.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 2) != 0);
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    sb_q.push_back(model(we, f3, a, wd));
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    while (!req_ready && n < 100) begin n++; @(negedge clk); end
    check("req_accept", 32'(req_ready), 32'd1);
    if (!req_ready) void'(sb_q.pop_back());
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom(); req_wdata = $urandom();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    check("drain", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    logic [31:0] w;
    int          n;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom();
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_wr", 32'(dmem_mem_wr), 32'd0);
    check("rst_mem_rd", 32'(dmem_mem_rd), 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    check("rst_wr_data", dmem_wr_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // word store/load, sub-word RMW and extension, misalignment, range and funct3 faults
    issue(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    issue(1'b0, 3'd2, 32'h10, 32'h0);
    issue(1'b1, 3'd0, 32'h12, 32'h0000_00AA);
    issue(1'b0, 3'd0, 32'h12, 32'h0);
    issue(1'b0, 3'd4, 32'h12, 32'h0);
    issue(1'b1, 3'd1, 32'h10, 32'h0000_1234);
    issue(1'b0, 3'd1, 32'h12, 32'h0);
    issue(1'b0, 3'd5, 32'h10, 32'h0);
    issue(1'b0, 3'd2, 32'h13, 32'h0);
    issue(1'b0, 3'd1, 32'h11, 32'h0);
    issue(1'b0, 3'd4, 32'(DEPTH*4 - 1), 32'h0);
    issue(1'b1, 3'd0, 32'(DEPTH*4 - 1), 32'h0000_0077);
    issue(1'b0, 3'd0, 32'(DEPTH*4), 32'h0);
    issue(1'b0, 3'd3, 32'h10, 32'h0);
    issue(1'b1, 3'd4, 32'h10, 32'h0);
    wait_idle();

    // response held under back-pressure
    rdy_mode = 2;
    issue(1'b0, 3'd2, 32'h100, 32'h0);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_rsp_err", 32'(rsp_err), 32'd2);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rdy_mode = 0;
    wait_idle();

    // reset during the read phase of a byte store
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h12; req_wdata = 32'h55;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin n++; @(negedge clk); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_pre_read", 32'(dmem_mem_rd), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_mem_rd", 32'(dmem_mem_rd), 32'd0);
    check("midrst_mem_wr", 32'(dmem_mem_wr), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_dmem_addr", dmem_addr, 32'd0);
    check("midrst_wr_data", dmem_wr_data, 32'd0);
    acc_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_word_kept", dmem[4], word_of(16));
    @(posedge clk); #1;
    issue(1'b0, 3'd2, 32'h10, 32'h0);
    issue(1'b0, 3'd0, 32'h12, 32'h0);
    wait_idle();

    // randomized traffic with back-pressure
    rdy_mode = 1;
    for (int k = 0; k < 300; k++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = we ? 3'($urandom_range(0, 2)) : legal_ld[$urandom_range(0, 4)];
      a = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, DEPTH*4 + 3));
      issue(we, f3, a, $urandom());
    end
    wait_idle();
    @(posedge clk); #1;
    rdy_mode = 0;

    for (int i = 0; i < DEPTH; i++) check("final_mem", dmem[i], word_of(4*i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
